// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single registered ALU, with lock/ownership and abandon timeout.
// Define ALU_ARB_FIXED_PRIO_EN to make idle ties always favour requester 0 instead of round-robin.
module alu_arbiter #(
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req0_lock,
    input  logic [31:0] req0_A,
    input  logic [31:0] req0_B,
    input  logic [5:0]  req0_ALUFun,
    input  logic        req0_Sign,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic        req1_lock,
    input  logic [31:0] req1_A,
    input  logic [31:0] req1_B,
    input  logic [5:0]  req1_ALUFun,
    input  logic        req1_Sign,
    output logic        req1_ready,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_Z,
    output logic        rsp_zero,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    localparam logic [4:0] LockMax = 5'(LOCK_MAX);

    state_e      state_q, state_d;
    logic        rr_q, rr_d;
    logic [3:0]  lock_cnt_q, lock_cnt_d;
    logic [1:0]  to_cnt_q, to_cnt_d;

    logic        op_valid_q, op_valid_d;
    logic        op_id_q, op_id_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [5:0]  op_fun_q, op_fun_d;
    logic        op_sign_q, op_sign_d;

    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_z_q, rsp_z_d;
    logic        rsp_zero_q, rsp_zero_d;

    logic        tie_pick, own_valid, acc, acc_id, acc_lock;
    logic [4:0]  lock_inc;
    logic [31:0] alu_z;
    logic        alu_zero;
    logic [4:0]  shamt;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign tie_pick = 1'b0;
`else
    assign tie_pick = rr_q;
`endif

    assign acc       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign acc_id    = req1_valid && req1_ready;
    assign acc_lock  = acc_id ? req1_lock : req0_lock;
    assign own_valid = (state_q == StOwn1) ? req1_valid : req0_valid;
    assign lock_inc  = {1'b0, lock_cnt_q} + 5'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            rr_q        <= 1'b0;
            lock_cnt_q  <= '0;
            to_cnt_q    <= '0;
            op_valid_q  <= 1'b0;
            op_id_q     <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_fun_q    <= '0;
            op_sign_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_z_q     <= '0;
            rsp_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            lock_cnt_q  <= lock_cnt_d;
            to_cnt_q    <= to_cnt_d;
            op_valid_q  <= op_valid_d;
            op_id_q     <= op_id_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_fun_q    <= op_fun_d;
            op_sign_q   <= op_sign_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_z_q     <= rsp_z_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        lock_cnt_d = lock_cnt_q;
        to_cnt_d   = to_cnt_q;
        // Every accept points the tie-break away from the requester just served.
        if (acc) begin
            rr_d = ~acc_id;
        end
        unique case (state_q)
            StIdle: begin
                to_cnt_d = '0;
                if (acc && acc_lock && (LockMax > 5'd1)) begin
                    state_d    = acc_id ? StOwn1 : StOwn0;
                    lock_cnt_d = 4'd1;
                end
            end
            StOwn0, StOwn1: begin
                if (acc) begin
                    to_cnt_d = '0;
                    if (!acc_lock || (lock_inc >= LockMax)) begin
                        state_d    = StIdle;
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_inc[3:0];
                    end
                end else if (!own_valid) begin
                    // Owner silent for four cycles in a row: give the ALU back.
                    if (to_cnt_q == 2'd3) begin
                        state_d    = StIdle;
                        lock_cnt_d = '0;
                        to_cnt_d   = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req0_valid && req1_valid) begin
                    req0_ready = !tie_pick;
                    req1_ready = tie_pick;
                end else begin
                    req0_ready = req0_valid;
                    req1_ready = req1_valid;
                end
            end
            StOwn0:  req0_ready = req0_valid;
            StOwn1:  req1_ready = req1_valid;
            default: ;
        endcase
    end

    always_comb begin
        op_valid_d = acc;
        op_id_d    = op_id_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_fun_d   = op_fun_q;
        op_sign_d  = op_sign_q;
        if (acc) begin
            op_id_d   = acc_id;
            op_a_d    = acc_id ? req1_A : req0_A;
            op_b_d    = acc_id ? req1_B : req0_B;
            op_fun_d  = acc_id ? req1_ALUFun : req0_ALUFun;
            op_sign_d = acc_id ? req1_Sign : req0_Sign;
        end
    end

    // The single shared ALU, fed only from the op-stage registers.
    assign shamt = op_b_q[4:0];
    always_comb begin
        alu_z = '0;
        case (op_fun_q)
            6'd0: alu_z = op_a_q + op_b_q;
            6'd1: alu_z = op_a_q - op_b_q;
            6'd2: alu_z = op_a_q & op_b_q;
            6'd3: alu_z = op_a_q | op_b_q;
            6'd4: alu_z = op_a_q ^ op_b_q;
            6'd5: alu_z = ~(op_a_q | op_b_q);
            6'd6: begin
                if (op_sign_q) alu_z = {31'd0, $signed(op_a_q) < $signed(op_b_q)};
                else           alu_z = {31'd0, op_a_q < op_b_q};
            end
            6'd7: alu_z = op_a_q << shamt;
            6'd8: begin
                if (op_sign_q) alu_z = $signed(op_a_q) >>> shamt;
                else           alu_z = op_a_q >> shamt;
            end
            default: alu_z = '0;
        endcase
    end
    assign alu_zero = (alu_z == 32'd0);

    always_comb begin
        rsp_valid_d = op_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_z_d     = rsp_z_q;
        rsp_zero_d  = rsp_zero_q;
        if (op_valid_q) begin
            rsp_id_d   = op_id_q;
            rsp_z_d    = alu_z;
            rsp_zero_d = alu_zero;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_Z     = rsp_z_q;
    assign rsp_zero  = rsp_zero_q;
    assign busy      = (state_q != StIdle) || op_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: per-cycle vector table for grants plus a response scoreboard.
module tb_alu_arbiter;

    localparam int unsigned LockMax = 3;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam logic Fixed = 1'b1;
`else
    localparam logic Fixed = 1'b0;
`endif
    localparam logic H  = 1'b1;
    localparam logic L  = 1'b0;
    localparam logic T0 = 1'b1;     // tie grant to req0 expected in both modes
    localparam logic R1 = ~Fixed;   // tie grant to req1 expected only in round-robin mode

    localparam logic [5:0] FAdd = 6'd0, FSub = 6'd1, FAnd = 6'd2, FOr = 6'd3, FXor = 6'd4;
    localparam logic [5:0] FNor = 6'd5, FSlt = 6'd6, FSll = 6'd7, FSr = 6'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_lock, req0_Sign, req0_ready;
    logic        req1_valid, req1_lock, req1_Sign, req1_ready;
    logic [31:0] req0_A, req0_B, req1_A, req1_B;
    logic [5:0]  req0_ALUFun, req1_ALUFun;
    logic        rsp_valid, rsp_id, rsp_zero, busy;
    logic [31:0] rsp_Z;

    always #5 clk = ~clk;

    alu_arbiter #(.LOCK_MAX(LockMax)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_lock  (req0_lock),
        .req0_A     (req0_A),
        .req0_B     (req0_B),
        .req0_ALUFun(req0_ALUFun),
        .req0_Sign  (req0_Sign),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_lock  (req1_lock),
        .req1_A     (req1_A),
        .req1_B     (req1_B),
        .req1_ALUFun(req1_ALUFun),
        .req1_Sign  (req1_Sign),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_Z      (rsp_Z),
        .rsp_zero   (rsp_zero),
        .busy       (busy)
    );

    typedef struct {
        logic v0, l0; logic [31:0] a0, b0; logic [5:0] f0; logic s0;
        logic v1, l1; logic [31:0] a1, b1; logic [5:0] f1; logic s1;
        logic r0, r1;
    } vec_t;

    typedef struct {
        int          due;
        logic        id;
        logic [31:0] z;
        logic        zero;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    exp_t        sb[$];
    vec_t        vecs[$];
    logic [31:0] last_z = 32'd0;
    logic        last_id = 1'b0;
    logic        last_zero = 1'b0;

    function automatic vec_t mk(input logic v0, l0, input logic [31:0] a0, b0,
                                input logic [5:0] f0, input logic s0,
                                input logic v1, l1, input logic [31:0] a1, b1,
                                input logic [5:0] f1, input logic s1,
                                input logic r0, r1);
        vec_t v;
        v.v0 = v0; v.l0 = l0; v.a0 = a0; v.b0 = b0; v.f0 = f0; v.s0 = s0;
        v.v1 = v1; v.l1 = l1; v.a1 = a1; v.b1 = b1; v.f1 = f1; v.s1 = s1;
        v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    function automatic logic [31:0] model(input logic [31:0] a, b, input logic [5:0] f,
                                          input logic s);
        logic [63:0] ext;
        logic        lt;
        case (f)
            FAdd: return a + b;
            FSub: return a + ~b + 32'd1;
            FAnd: return a & b;
            FOr:  return a | b;
            FXor: return a ^ b;
            FNor: return ~(a | b);
            FSlt: begin
                if (s && (a[31] != b[31])) lt = a[31];
                else                       lt = (a < b);
                return {31'd0, lt};
            end
            FSll: return a << b[4:0];
            FSr: begin
                ext = {(s ? {32{a[31]}} : 32'd0), a};
                ext = ext >> b[4:0];
                return ext[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_rsp();
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_Z", rsp_Z, e.z);
            chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
            last_z = e.z; last_id = e.id; last_zero = e.zero;
        end else begin
            chk("rsp_valid idle", 32'(rsp_valid), 32'd0);
            chk("rsp_Z hold", rsp_Z, last_z);
            chk("rsp_id hold", 32'(rsp_id), 32'(last_id));
            chk("rsp_zero hold", 32'(rsp_zero), 32'(last_zero));
        end
    endtask

    task automatic push_exp(input logic [31:0] a, b, input logic [5:0] f, input logic s,
                            input logic id);
        exp_t e;
        e.due  = cyc + 1;
        e.id   = id;
        e.z    = model(a, b, f, s);
        e.zero = (e.z == 32'd0);
        sb.push_back(e);
    endtask

    task automatic apply(input vec_t v);
        req0_valid = v.v0; req0_lock = v.l0; req0_A = v.a0; req0_B = v.b0;
        req0_ALUFun = v.f0; req0_Sign = v.s0;
        req1_valid = v.v1; req1_lock = v.l1; req1_A = v.a1; req1_B = v.b1;
        req1_ALUFun = v.f1; req1_Sign = v.s1;
    endtask

    // Checks ready/response mid-cycle, then records the accept at the next rising edge.
    task automatic tick(input logic er0, input logic er1);
        @(negedge clk);
        chk("req0_ready", 32'(req0_ready), 32'(er0));
        chk("req1_ready", 32'(req1_ready), 32'(er1));
        check_rsp();
        @(posedge clk);
        cyc++;
        if (req0_valid && er0) push_exp(req0_A, req0_B, req0_ALUFun, req0_Sign, 1'b0);
        if (req1_valid && er1) push_exp(req1_A, req1_B, req1_ALUFun, req1_Sign, 1'b1);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_id", 32'(rsp_id), 32'd0);
        chk("reset rsp_Z", rsp_Z, 32'd0);
        chk("reset rsp_zero", 32'(rsp_zero), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
    endtask

    vec_t idle;

    initial begin
        idle = mk(L, L, 32'd0, 32'd0, FAdd, L, L, L, 32'd0, 32'd0, FAdd, L, L, L);
        reset = 1'b0;
        apply(idle);
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1 reset = 1'b1;

        // Ties without lock: 0,1,0,1 round-robin (0,0,0,0 fixed priority).
        vecs.push_back(mk(H, L, 32'h10, 32'h3, FAdd, L, H, L, 32'h10, 32'h3, FSub, L, T0, L));
        vecs.push_back(mk(H, L, 32'hF0F0, 32'hFF00, FAnd, L, H, L, 32'hF0F0, 32'h0F0F, FOr, L,
                          Fixed, R1));
        vecs.push_back(mk(H, L, 32'hAAAA5555, 32'hFFFF0000, FXor, L,
                          H, L, 32'hFFFFFFFF, 32'h1, FSlt, H, T0, L));
        vecs.push_back(mk(H, L, 32'h80000000, 32'd4, FSr, H, H, L, 32'h80000000, 32'd4, FSr, L,
                          Fixed, R1));
        // Single ops: 5+3, then 0x80000000-0x80000000 giving zero.
        vecs.push_back(mk(H, L, 32'd5, 32'd3, FAdd, L, L, L, 32'd0, 32'd0, FAdd, L, H, L));
        vecs.push_back(mk(L, L, 32'd0, 32'd0, FAdd, L,
                          H, L, 32'h80000000, 32'h80000000, FSub, L, L, H));
        vecs.push_back(idle);
        // Lock by req1 for LOCK_MAX=3 accepts while req0 keeps asking.
        vecs.push_back(mk(L, L, 32'd0, 32'd0, FAdd, L, H, H, 32'd1, 32'd1, FAdd, L, L, H));
        vecs.push_back(mk(H, L, 32'd9, 32'd9, FNor, L, H, H, 32'hFFFFFFFF, 32'd1, FSlt, L, L, H));
        vecs.push_back(mk(H, L, 32'd9, 32'd9, FNor, L, H, H, 32'd1, 32'd31, FSll, L, L, H));
        // req0 locks once, then goes silent: four cycles of lockout, then req1 served.
        vecs.push_back(mk(H, H, 32'd9, 32'd6, FNor, L, H, L, 32'd2, 32'd2, FAdd, L, H, L));
        for (int i = 0; i < 4; i++) begin
            vecs.push_back(mk(L, L, 32'd0, 32'd0, FAdd, L, H, L, 32'd2, 32'd2, FAdd, L, L, L));
        end
        vecs.push_back(mk(L, L, 32'd0, 32'd0, FAdd, L, H, H, 32'd2, 32'd3, FAdd, L, L, H));
        // Owner drops lock: back to idle with req0 favoured next.
        vecs.push_back(mk(H, L, 32'd4, 32'd4, FSub, L, H, L, 32'd7, 32'd1, FSub, L, L, H));
        vecs.push_back(mk(H, L, 32'd4, 32'd4, FSub, L, H, L, 32'd7, 32'd1, FSub, L, T0, L));
        vecs.push_back(mk(H, L, 32'd6, 32'd1, FSll, L, H, L, 32'd8, 32'd2, FSr, L, Fixed, R1));
        vecs.push_back(idle);

        foreach (vecs[i]) begin
            apply(vecs[i]);
            tick(vecs[i].r0, vecs[i].r1);
        end
        apply(idle);
        repeat (3) tick(L, L);

        // Reset while an op sits in the op stage: it must vanish.
        apply(mk(H, L, 32'd7, 32'd9, FAdd, L, L, L, 32'd0, 32'd0, FAdd, L, H, L));
        tick(H, L);
        chk("busy in flight", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check_reset_outputs();
        sb.delete();
        last_z = 32'd0; last_id = 1'b0; last_zero = 1'b0;
        apply(idle);
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b1;

        // First edge after release accepts; tie goes to req0 after reset.
        apply(mk(H, L, 32'd1, 32'd2, FAdd, L, H, L, 32'd3, 32'd3, FXor, L, T0, L));
        tick(H, L);
        apply(mk(L, L, 32'd0, 32'd0, FAdd, L, H, L, 32'd3, 32'd3, FXor, L, L, H));
        tick(L, H);
        apply(idle);
        repeat (3) tick(L, L);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
